// File: rtl/img_udp_pkt.sv
// img_udp_pkt: gates camera frames on transfer_flag, packs 16-bit pixels into a
// 32-bit line buffer, and feeds udp_tx one packet per line (frame header on line 0).
module img_udp_pkt #(
  parameter int          H_PIXEL    = 640,
  parameter int          V_PIXEL    = 480,
  parameter logic [31:0] FRAME_HEAD = 32'hF05A_A50F,
  parameter int          BUF_DEPTH  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transfer_flag,
  input  logic        img_vsync,
  input  logic        img_data_en,
  input  logic [15:0] img_data,
  input  logic        udp_tx_req,
  input  logic        udp_tx_done,
  output logic        udp_tx_start_en,
  output logic [15:0] udp_tx_byte_num,
  output logic [31:0] udp_tx_data,
  output logic        buf_overflow
);
  localparam int LW = H_PIXEL / 2;
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int WW = $clog2(LW + 2);
  localparam int VW = $clog2(V_PIXEL + 1);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINE = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;
  state_t          state_q;
  logic            vs_q, vs_prev_q, active_q, phase_q;
  logic [15:0]     hi_q;
  logic [31:0]     mem [BUF_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   line_q;
  logic [WW-1:0]   word_q, last_word;
  logic            accept, line0, issue, head, pop, wr_try, push;
  always_comb begin
    accept    = vs_q && !vs_prev_q && state_q == IDLE && transfer_flag;
    line0     = line_q == '0;
    last_word = line0 ? WW'(LW) : WW'(LW - 1);
    issue     = state_q == SEND && udp_tx_req;
    head      = issue && line0 && word_q == '0;
    pop       = issue && !head;
    wr_try    = active_q && img_data_en && phase_q;
    push      = wr_try && (cnt_q != CW'(BUF_DEPTH) || pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) if (push) mem[wr_q] <= {hi_q, img_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      vs_q            <= 1'b0;
      vs_prev_q       <= 1'b0;
      active_q        <= 1'b0;
      phase_q         <= 1'b0;
      hi_q            <= '0;
      wr_q            <= '0;
      rd_q            <= '0;
      cnt_q           <= '0;
      line_q          <= '0;
      word_q          <= '0;
      udp_tx_start_en <= 1'b0;
      udp_tx_byte_num <= '0;
      udp_tx_data     <= '0;
      buf_overflow    <= 1'b0;
    end else begin
      vs_q            <= img_vsync;
      vs_prev_q       <= vs_q;
      cnt_q           <= cnt_d;
      udp_tx_start_en <= 1'b0;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (wr_try && !push) buf_overflow <= 1'b1;
      if (issue) udp_tx_data <= head ? FRAME_HEAD : mem[rd_q];
      if (accept) begin
        active_q <= 1'b1;
        phase_q  <= 1'b0;
      end else if (active_q && img_data_en) begin
        phase_q <= ~phase_q;
        if (!phase_q) hi_q <= img_data;
      end
      case (state_q)
        IDLE: if (accept) begin
          state_q <= WAIT_LINE;
          line_q  <= '0;
          word_q  <= '0;
        end
        WAIT_LINE: if (cnt_q >= CW'(LW)) begin
          state_q         <= START;
          udp_tx_start_en <= 1'b1;
          udp_tx_byte_num <= line0 ? 16'(2 * H_PIXEL + 4) : 16'(2 * H_PIXEL);
          word_q          <= '0;
        end
        START: state_q <= SEND;
        SEND: if (udp_tx_req) begin
          word_q <= word_q + 1'b1;
          if (word_q == last_word) state_q <= WAIT_DONE;
        end
        WAIT_DONE: if (udp_tx_done) begin
          line_q <= line_q + 1'b1;
          if (line_q == VW'(V_PIXEL - 1)) begin
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else state_q <= WAIT_LINE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_img_udp_pkt.sv
// tb_img_udp_pkt: scoreboard bench for img_udp_pkt with a small udp_tx model.
module tb_img_udp_pkt;
  logic        clk = 1'b0, rst = 1'b1, transfer_flag = 1'b0, img_vsync = 1'b0;
  logic        img_data_en = 1'b0, udp_tx_req = 1'b0, udp_tx_done = 1'b0;
  logic [15:0] img_data = '0;
  logic        udp_tx_start_en, buf_overflow;
  logic [15:0] udp_tx_byte_num;
  logic [31:0] udp_tx_data;
  int          tests = 0, fails = 0;
  int          bq[$];
  logic [31:0] dq[$];
  img_udp_pkt #(.H_PIXEL(4), .V_PIXEL(2), .FRAME_HEAD(32'hF05A_A50F), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .transfer_flag(transfer_flag), .img_vsync(img_vsync),
    .img_data_en(img_data_en), .img_data(img_data), .udp_tx_req(udp_tx_req),
    .udp_tx_done(udp_tx_done), .udp_tx_start_en(udp_tx_start_en),
    .udp_tx_byte_num(udp_tx_byte_num), .udp_tx_data(udp_tx_data), .buf_overflow(buf_overflow)
  );
  always #5 clk = ~clk;
  task automatic vsync_pulse(input bit exp);
    if (exp) begin
      bq.push_back(12);
      bq.push_back(8);
      dq.push_back(32'hF05A_A50F);
    end
    @(negedge clk) img_vsync = 1'b1;
    repeat (3) @(negedge clk);
    img_vsync = 1'b0;
    @(negedge clk);
  endtask
  task automatic feed(input logic [15:0] base, input int n, input bit exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      img_data_en = 1'b1;
      img_data    = base + 16'(i);
      if (exp && i % 2 == 1) dq.push_back({img_data - 16'd1, img_data});
    end
    @(negedge clk) img_data_en = 1'b0;
  endtask
  task automatic tx_packet();
    int t = 0;
    int eb, n;
    logic [31:0] ed;
    while (!udp_tx_start_en && t < 200) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (!udp_tx_start_en) begin
      fails++;
      $display("FAIL start_timeout: start_en=%0b required 1", udp_tx_start_en);
      return;
    end
    eb = bq.size() > 0 ? bq.pop_front() : 0;
    tests++;
    if (udp_tx_byte_num !== 16'(eb)) begin
      fails++;
      $display("FAIL byte_num: got %0d required %0d", udp_tx_byte_num, eb);
    end
    n = eb / 4;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      udp_tx_req = 1'b1;
      @(negedge clk);
      ed = dq.size() > 0 ? dq.pop_front() : 32'hDEAD_BEEF;
      tests++;
      if (udp_tx_data !== ed) begin
        fails++;
        $display("FAIL tx_data[%0d]: got %h required %h", i, udp_tx_data, ed);
      end
    end
    udp_tx_req = 1'b0;
    repeat (2) @(negedge clk);
    udp_tx_done = 1'b1;
    @(negedge clk) udp_tx_done = 1'b0;
  endtask
  task automatic check_idle(input string name, input int line_exp);
    logic [2:0] st;
    st = dut.state_q;
    tests++;
    if (st !== 3'd0 || int'(dut.line_q) != line_exp) begin
      fails++;
      $display("FAIL %s: state=%0d line=%0d required state=0 line=%0d", name, st, dut.line_q, line_exp);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({udp_tx_start_en, udp_tx_byte_num, udp_tx_data, buf_overflow} !== 50'd0 || dut.cnt_q !== '0) begin
      fails++;
      $display("FAIL reset_outputs: start=%0b bn=%0d data=%h ovf=%0b required all 0",
               udp_tx_start_en, udp_tx_byte_num, udp_tx_data, buf_overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic();
    transfer_flag = 1'b1;
    vsync_pulse(1);
    fork
      feed(16'h0001, 8, 1);
      begin tx_packet(); tx_packet(); end
    join
    repeat (3) @(negedge clk);
    check_idle("basic_idle", 2);
    tests++;
    if (udp_tx_data !== 32'h0007_0008) begin
      fails++;
      $display("FAIL data_hold: got %h required 00070008", udp_tx_data);
    end
  endtask
  task automatic test_flag_gating();
    int starts = 0;
    transfer_flag = 1'b0;
    vsync_pulse(0);
    fork
      feed(16'h0021, 8, 0);
      repeat (30) @(negedge clk) starts += int'(udp_tx_start_en);
    join
    tests++;
    if (starts != 0 || dut.cnt_q !== '0) begin
      fails++;
      $display("FAIL gated_frame: starts=%0d cnt=%0d required 0 0", starts, dut.cnt_q);
    end
    transfer_flag = 1'b1;
    vsync_pulse(1);
    fork
      feed(16'h0011, 8, 1);
      begin tx_packet(); tx_packet(); end
    join
    repeat (3) @(negedge clk);
    check_idle("gated_then_sent", 2);
  endtask
  task automatic test_flag_drop();
    int starts = 0;
    transfer_flag = 1'b1;
    vsync_pulse(1);
    fork
      feed(16'h0031, 8, 1);
      begin tx_packet(); transfer_flag = 1'b0; tx_packet(); end
    join
    vsync_pulse(0);
    fork
      feed(16'h0041, 8, 0);
      repeat (30) @(negedge clk) starts += int'(udp_tx_start_en);
    join
    tests++;
    if (starts != 0) begin
      fails++;
      $display("FAIL flag0_vsync: starts=%0d required 0", starts);
    end
    check_idle("flag_drop_idle", 2);
  endtask
  task automatic test_vsync_in_send();
    transfer_flag = 1'b1;
    vsync_pulse(1);
    fork
      feed(16'h0051, 8, 1);
      begin tx_packet(); tx_packet(); end
      begin
        int t = 0;
        while (dut.state_q != 3'd3 && t < 100) begin
          @(negedge clk);
          t++;
        end
        tests++;
        if (dut.state_q != 3'd3) begin
          fails++;
          $display("FAIL reach_send: state=%0d required 3", dut.state_q);
        end
        vsync_pulse(0);
      end
    join
    repeat (3) @(negedge clk);
    check_idle("vsync_in_send", 2);
  endtask
  task automatic test_overflow();
    transfer_flag = 1'b1;
    vsync_pulse(0);
    feed(16'h0101, 8, 0);
    tests++;
    if (buf_overflow !== 1'b0 || dut.cnt_q != 4) begin
      fails++;
      $display("FAIL full_no_ovf: ovf=%0b cnt=%0d required 0 4", buf_overflow, dut.cnt_q);
    end
    feed(16'h0109, 4, 0);
    tests++;
    if (buf_overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: ovf=%0b required 1", buf_overflow);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (buf_overflow !== 1'b1 || dut.cnt_q != 4) begin
      fails++;
      $display("FAIL ovf_sticky: ovf=%0b cnt=%0d required 1 4", buf_overflow, dut.cnt_q);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tests++;
    if (buf_overflow !== 1'b0 || dut.cnt_q != 0) begin
      fails++;
      $display("FAIL ovf_rst: ovf=%0b cnt=%0d required 0 0", buf_overflow, dut.cnt_q);
    end
    check_idle("ovf_rst_idle", 0);
  endtask
  task automatic test_rst_mid_send();
    int t = 0;
    transfer_flag = 1'b1;
    vsync_pulse(0);
    feed(16'h0201, 4, 0);
    while (!udp_tx_start_en && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk) udp_tx_req = 1'b1;
    @(negedge clk);
    tests++;
    if (udp_tx_data !== 32'hF05A_A50F) begin
      fails++;
      $display("FAIL pre_rst_head: got %h required f05aa50f", udp_tx_data);
    end
    udp_tx_req = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tests++;
    if ({udp_tx_start_en, udp_tx_byte_num, udp_tx_data, buf_overflow} !== 50'd0) begin
      fails++;
      $display("FAIL rst_mid_send: start=%0b bn=%0d data=%h ovf=%0b required all 0",
               udp_tx_start_en, udp_tx_byte_num, udp_tx_data, buf_overflow);
    end
    check_idle("rst_mid_idle", 0);
    vsync_pulse(1);
    fork
      feed(16'h0301, 8, 1);
      begin tx_packet(); tx_packet(); end
    join
    tests++;
    if (bq.size() != 0 || dq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: bytes=%0d words=%0d required 0 0", bq.size(), dq.size());
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_flag_gating();
    test_flag_drop();
    test_vsync_in_send();
    test_overflow();
    test_rst_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/img_udp_pkt.md
Name: img_udp_pkt

Overview:
- Downstream consumer of the UDP start/stop command flag (transfer_flag).
- Gates camera frames on that flag and packs 16-bit pixels into 32-bit words in an internal line buffer.
- Drives the UDP transmit engine with one packet per image line; the first line of each frame carries a 4-byte frame header.
- Sits between the camera/video capture path and udp_tx, in the single eth clock domain.

Parameters:
H_PIXEL, 640, pixels per line; must be even, and H_PIXEL/2 must not exceed BUF_DEPTH.
V_PIXEL, 480, lines per frame.
FRAME_HEAD, 32'hF05A_A50F, header word sent before the first line of a frame.
BUF_DEPTH, 1024, line buffer depth in 32-bit words; power of two.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
transfer_flag  in  1  1 = transmit frames, 0 = stop (from the command decoder).
img_vsync  in  1  frame sync, active high; its rising edge marks frame start.
img_data_en  in  1  pixel valid strobe.
img_data  in  16  pixel data.
udp_tx_req  in  1  udp_tx requests the next 32-bit word.
udp_tx_done  in  1  one-cycle pulse: packet fully sent.
udp_tx_start_en  out  1  one-cycle pulse: start a packet.
udp_tx_byte_num  out  16  byte count of the packet being started.
udp_tx_data  out  32  transmit word.
buf_overflow  out  1  sticky flag: a pixel word was dropped because the buffer was full.

Behaviour:
- Reset values: udp_tx_start_en=0, udp_tx_byte_num=0, udp_tx_data=0, buf_overflow=0. Buffer is emptied, FSM returns to IDLE, all counters are cleared.
- Reset mid-packet aborts immediately; there is no drain.
- Frame gating:
  - img_vsync is registered once; a rise is detected from the registered value versus the previous value.
  - On a vsync rise in IDLE with transfer_flag=1, frame_active is set and the line and pixel counters are cleared.
  - A vsync rise in any other state is ignored.
  - transfer_flag falling mid-frame does not truncate; the frame completes all V_PIXEL lines.
- Packing:
  - Only while frame_active, img_data_en pixels alternate even/odd.
  - Even pixel goes to [31:16], odd pixel to [15:0].
  - The word is written to the buffer on the odd pixel.
  - A pixel phase counter resets per frame.
  - Pixels are discarded when frame_active=0.
- Buffer full on a write: the word is dropped and buf_overflow is set. The flag is cleared only by rst.
- A simultaneous buffer write and read is allowed; the count is unchanged.
- FSM states: IDLE, WAIT_LINE, START, SEND, WAIT_DONE.
  - IDLE -> WAIT_LINE on an accepted vsync rise.
  - WAIT_LINE -> START when buffer count >= H_PIXEL/2.
  - START: assert udp_tx_start_en for exactly one cycle. Set udp_tx_byte_num = 2*H_PIXEL+4 for line 0, else 2*H_PIXEL. Go to SEND.
  - SEND: each udp_tx_req yields one word, valid on udp_tx_data the cycle after req.
    - On line 0 the first requested word is FRAME_HEAD, followed by H_PIXEL/2 buffer words.
    - On other lines there are H_PIXEL/2 buffer words only.
    - After the last word is issued, go to WAIT_DONE.
  - WAIT_DONE: on udp_tx_done, increment the line counter. If line = V_PIXEL-1, clear frame_active and go to IDLE; otherwise go to WAIT_LINE.
- Requests:
  - A udp_tx_req outside SEND, or beyond the packet word count, does not pop the buffer.
  - udp_tx_data holds its last value when there is no req.
- udp_tx_done outside WAIT_DONE is ignored.
- udp_tx_byte_num holds its value until the next START.
- Word counter width is clog2(H_PIXEL/2+2). Line counter width is clog2(V_PIXEL+1).
- Latency: START is asserted 1 cycle after the buffer count reaches the line threshold.

Test Plan:
- H_PIXEL=4, V_PIXEL=2, transfer_flag=1, vsync rise, then 8 pixels 16'h0001..16'h0008 with a udp_tx model (req after start, done 2 cycles after last word). Required: packet 1 has byte_num=12, data F05AA50F, 00010002, 00030004. Packet 2 has byte_num=8, data 00050006, 00070008. FSM returns to IDLE.
- transfer_flag=0 at vsync rise, pixels supplied -> no udp_tx_start_en and buffer count stays 0. Set flag=1 and send the next vsync -> the frame is transmitted.
- transfer_flag drops after line 0 of a frame -> line 1 is still sent. The next vsync with flag=0 is ignored.
- Second vsync rise while in SEND -> ignored; the frame completes normally and the line count ends at V_PIXEL.
- BUF_DEPTH=4, H_PIXEL=4, udp_tx_req held low so the buffer fills, then 2 more words supplied -> buf_overflow=1 and remains 1 until rst.
- rst pulsed during SEND on line 0 -> all outputs 0 next cycle and FSM in IDLE. The next vsync with flag=1 sends FRAME_HEAD first.
